// File: rtl/instr_mem_pkg.sv
//------------------------------------------------------------------------------
// Module : instr_mem_pkg
// Brief  : Shared types, defaults and helpers for the instruction memory controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package instr_mem_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_TURN    = 3'd4
  } state_t;

  // Counter width for a 0..lat-1 count; never narrower than one bit.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : instr_mem_ctrl_if
// Brief  : Loader (write) and fetch (read) request ports of the controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_mem_ctrl_if
  import instr_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          fe_req;
  logic          fe_gnt;
  logic [AW-1:0] fe_addr;
  logic [DW-1:0] fe_rdata;
  logic          fe_rvalid;

  modport master (
    output ld_valid, ld_addr, ld_data, fe_req, fe_addr,
    input  ld_ready, fe_gnt, fe_rdata, fe_rvalid
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, fe_req, fe_addr,
    output ld_ready, fe_gnt, fe_rdata, fe_rvalid
  );

endinterface

`default_nettype wire

// File: rtl/imem_arb.sv
//------------------------------------------------------------------------------
// Module : imem_arb
// Brief  : Loader-first arbiter with a streak counter that lets a waiting fetch in.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ld_valid,
  input  logic fe_req,
  output logic sel_ld,
  output logic sel_fe
);

  localparam int            SW           = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] C_STREAK_MAX = SW'(STARVE_MAX);

  logic [SW-1:0] r_streak;
  logic          w_starved;

  assign w_starved = (r_streak == C_STREAK_MAX);
  assign sel_fe    = en & fe_req & (~ld_valid | w_starved);
  assign sel_ld    = en & ld_valid & ~sel_fe;

  // Streak only measures loader grants taken while a fetch is actually waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (!fe_req || sel_fe) begin
      r_streak <= '0;
    end else if (sel_ld && !w_starved) begin
      r_streak <= r_streak + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module : instr_mem_ctrl
// Brief  : Sequencer for a shared-bus 256x8 instruction memory (loader writes, fetch reads).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_mem_ctrl_if.slave bus,
  output logic            mem_cs,
  output logic            mem_we,
  output logic            mem_oe,
  output logic [AW-1:0]   mem_addr,
  inout  wire  [DW-1:0]   mem_data,
  output logic            busy
);

  localparam int            CW         = lat_cnt_w(RD_LAT);
  localparam logic [CW-1:0] C_LAT_LAST = CW'(RD_LAT - 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_lat;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          w_idle;
  logic          w_sel_ld;
  logic          w_sel_fe;
  logic          w_lat_last;
  logic          w_drive;
  logic          w_rvalid;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_lat_last = (r_lat == C_LAT_LAST);

  imem_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_idle),
    .ld_valid (bus.ld_valid),
    .fe_req   (bus.fe_req),
    .sel_ld   (w_sel_ld),
    .sel_fe   (w_sel_fe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_oe     = 1'b0;
    w_drive    = 1'b0;
    w_rvalid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_ld) begin
          w_state_nx = ST_WR;
        end else if (w_sel_fe) begin
          w_state_nx = ST_RD_ADDR;
        end
      end
      ST_WR: begin
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        w_drive    = 1'b1;
        w_state_nx = ST_IDLE;
      end
      ST_RD_ADDR: begin
        mem_cs     = 1'b1;
        w_state_nx = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        mem_cs = 1'b1;
        mem_oe = 1'b1;
        if (w_lat_last) begin
          w_state_nx = ST_TURN;
        end
      end
      // Dead cycle after oe falls so a following write cannot collide with the memory driver.
      ST_TURN: begin
        w_rvalid   = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_sel_ld) begin
        r_addr  <= bus.ld_addr;
        r_wdata <= bus.ld_data;
      end else if (w_sel_fe) begin
        r_addr  <= bus.fe_addr;
      end
      if (r_state == ST_RD_ADDR) begin
        r_lat <= '0;
      end else if (r_state == ST_RD_WAIT && !w_lat_last) begin
        r_lat <= r_lat + 1'b1;
      end
      if (r_state == ST_RD_WAIT && w_lat_last) begin
        r_rdata <= mem_data;
      end
    end
  end

  assign mem_data      = w_drive ? r_wdata : {DW{1'bz}};
  assign mem_addr      = r_addr;
  assign busy          = ~w_idle;
  assign bus.ld_ready  = w_sel_ld;
  assign bus.fe_gnt    = w_sel_fe;
  assign bus.fe_rdata  = r_rdata;
  assign bus.fe_rvalid = w_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_instr_mem_ctrl
// Brief  : Directed, table-driven bench for instr_mem_ctrl (RD_LAT=1 and RD_LAT=3 instances).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_ctrl;

  localparam logic [7:0] C_IDLE_BUS = 8'hC3;

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // RD_LAT = 1 instance with a byte-array memory model
  instr_mem_ctrl_if #(.AW(8), .DW(8)) l1 ();
  logic       mem_cs1, mem_we1, mem_oe1, busy1;
  logic [7:0] mem_addr1;
  wire  [7:0] mem_data1;
  logic [7:0] mem1 [256];
  logic [7:0] rd1;
  logic       tb_en1;
  logic [7:0] tb_val1;

  instr_mem_ctrl #(.AW(8), .DW(8), .RD_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (l1),
    .mem_cs   (mem_cs1),
    .mem_we   (mem_we1),
    .mem_oe   (mem_oe1),
    .mem_addr (mem_addr1),
    .mem_data (mem_data1),
    .busy     (busy1)
  );

  // When the controller is not writing, the bench drives memory data (oe) or a marker value,
  // so any stray controller drive shows up as a corrupted bus value.
  assign rd1       = mem1[mem_addr1];
  assign tb_en1    = ~mem_we1;
  assign tb_val1   = mem_oe1 ? rd1 : C_IDLE_BUS;
  assign mem_data1 = tb_en1 ? tb_val1 : 8'bz;

  always @(posedge clk) begin
    if (mem_cs1 && mem_we1) mem1[mem_addr1] <= mem_data1;
  end

  // RD_LAT = 3 instance; data is only valid on the third oe cycle
  instr_mem_ctrl_if #(.AW(8), .DW(8)) l3 ();
  logic       mem_cs3, mem_we3, mem_oe3, busy3;
  logic [7:0] mem_addr3;
  wire  [7:0] mem_data3;
  logic [7:0] rd3;
  logic       tb_en3;
  logic [7:0] tb_val3;
  int         oe_cnt3 = 0;

  instr_mem_ctrl #(.AW(8), .DW(8), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (l3),
    .mem_cs   (mem_cs3),
    .mem_we   (mem_we3),
    .mem_oe   (mem_oe3),
    .mem_addr (mem_addr3),
    .mem_data (mem_data3),
    .busy     (busy3)
  );

  assign rd3       = (oe_cnt3 == 2) ? (mem_addr3 ^ 8'h5A) : 8'hEE;
  assign tb_en3    = ~mem_we3;
  assign tb_val3   = mem_oe3 ? rd3 : C_IDLE_BUS;
  assign mem_data3 = tb_en3 ? tb_val3 : 8'bz;

  always @(posedge clk) begin
    oe_cnt3 <= mem_oe3 ? oe_cnt3 + 1 : 0;
  end

  // Continuous protocol checks
  always @(negedge clk) begin
    if (mem_oe1 && mem_we1) begin
      fails++;
      $display("FAIL bus_conflict1: oe=%0b we=%0b required not both", mem_oe1, mem_we1);
    end
    if (mem_oe3 && mem_we3) begin
      fails++;
      $display("FAIL bus_conflict3: oe=%0b we=%0b required not both", mem_oe3, mem_we3);
    end
    if (l1.ld_ready && l1.fe_gnt) begin
      fails++;
      $display("FAIL double_grant: ld_ready=1 fe_gnt=1 required at most one");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    l1.ld_valid = 1'b1;
    l1.ld_addr  = a;
    l1.ld_data  = d;
    #1;
    n = 0;
    while (!l1.ld_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("wr_grant", {31'd0, l1.ld_ready}, 32'd1);
    @(negedge clk);
    l1.ld_valid = 1'b0;
    #1;
    chk("wr_cs",   {31'd0, mem_cs1}, 32'd1);
    chk("wr_we",   {31'd0, mem_we1}, 32'd1);
    chk("wr_oe",   {31'd0, mem_oe1}, 32'd0);
    chk("wr_addr", {24'd0, mem_addr1}, {24'd0, a});
    chk("wr_bus",  {24'd0, mem_data1}, {24'd0, d});
    @(negedge clk); #1;
    chk("wr_release", {24'd0, mem_data1}, {24'd0, C_IDLE_BUS});
    chk("wr_busy",    {31'd0, busy1}, 32'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
    int n;
    @(negedge clk);
    l1.fe_req  = 1'b1;
    l1.fe_addr = a;
    #1;
    n = 0;
    while (!l1.fe_gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rd_grant", {31'd0, l1.fe_gnt}, 32'd1);
    @(negedge clk);
    l1.fe_req = 1'b0;
    #1;
    chk("rd_addr_cs",   {31'd0, mem_cs1}, 32'd1);
    chk("rd_addr_oe",   {31'd0, mem_oe1}, 32'd0);
    chk("rd_addr_addr", {24'd0, mem_addr1}, {24'd0, a});
    chk("rd_addr_bus",  {24'd0, mem_data1}, {24'd0, C_IDLE_BUS});
    @(negedge clk); #1;
    chk("rd_wait_oe",   {31'd0, mem_oe1}, 32'd1);
    chk("rd_wait_we",   {31'd0, mem_we1}, 32'd0);
    @(negedge clk); #1;
    chk("rd_rvalid",    {31'd0, l1.fe_rvalid}, 32'd1);
    chk("rd_data",      {24'd0, l1.fe_rdata}, {24'd0, exp});
    chk("rd_turn_cs",   {31'd0, mem_cs1}, 32'd0);
    chk("rd_turn_bus",  {24'd0, mem_data1}, {24'd0, C_IDLE_BUS});
    @(negedge clk); #1;
    chk("rd_rvalid_pulse", {31'd0, l1.fe_rvalid}, 32'd0);
    chk("rd_data_hold",    {24'd0, l1.fe_rdata}, {24'd0, exp});
    chk("rd_busy",         {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    vec_t  vecs [10];
    string got;
    int    n;
    int    rv_seen;

    vecs[0] = '{1'b1, 8'h10, 8'hA5};
    vecs[1] = '{1'b1, 8'h20, 8'h3C};
    vecs[2] = '{1'b1, 8'hFF, 8'h7E};
    vecs[3] = '{1'b1, 8'h00, 8'h81};
    vecs[4] = '{1'b0, 8'h10, 8'hA5};
    vecs[5] = '{1'b0, 8'hFF, 8'h7E};
    vecs[6] = '{1'b0, 8'h20, 8'h3C};
    vecs[7] = '{1'b0, 8'h00, 8'h81};
    vecs[8] = '{1'b1, 8'h10, 8'h5B};
    vecs[9] = '{1'b0, 8'h10, 8'h5B};

    l1.ld_valid = 1'b0; l1.ld_addr = '0; l1.ld_data = '0;
    l1.fe_req   = 1'b0; l1.fe_addr = '0;
    l3.ld_valid = 1'b0; l3.ld_addr = '0; l3.ld_data = '0;
    l3.fe_req   = 1'b0; l3.fe_addr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs",     {31'd0, mem_cs1}, 32'd0);
    chk("rst_we",     {31'd0, mem_we1}, 32'd0);
    chk("rst_oe",     {31'd0, mem_oe1}, 32'd0);
    chk("rst_busy",   {31'd0, busy1}, 32'd0);
    chk("rst_addr",   {24'd0, mem_addr1}, 32'd0);
    chk("rst_rdata",  {24'd0, l1.fe_rdata}, 32'd0);
    chk("rst_rvalid", {31'd0, l1.fe_rvalid}, 32'd0);
    chk("rst_bus",    {24'd0, mem_data1}, {24'd0, C_IDLE_BUS});
    chk("rst_ready3", {31'd0, l3.ld_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: writes then reads back
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else               do_read(vecs[i].addr, vecs[i].data);
    end

    // Starvation: both requesting continuously
    @(negedge clk);
    l1.ld_valid = 1'b1; l1.ld_addr = 8'h40; l1.ld_data = 8'h11;
    l1.fe_req   = 1'b1; l1.fe_addr = 8'h40;
    got = "";
    n = 0;
    while (got.len() < 10 && n < 200) begin
      #1;
      if (l1.ld_ready)     got = {got, "L"};
      else if (l1.fe_gnt)  got = {got, "F"};
      @(negedge clk);
      n++;
    end
    l1.ld_valid = 1'b0;
    l1.fe_req   = 1'b0;
    tests++;
    if (got != "LLLLFLLLLF") begin
      fails++;
      $display("FAIL starve_order: got %s required LLLLFLLLLF", got);
    end
    n = 0;
    #1;
    while (busy1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("starve_drain", {31'd0, busy1}, 32'd0);

    // Read followed by a pending write: one TURN cycle in between
    @(negedge clk);
    l1.fe_req = 1'b1; l1.fe_addr = 8'h20;
    #1;
    n = 0;
    while (!l1.fe_gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rw_grant", {31'd0, l1.fe_gnt}, 32'd1);
    @(negedge clk);
    l1.fe_req = 1'b0;
    l1.ld_valid = 1'b1; l1.ld_addr = 8'h50; l1.ld_data = 8'h66;
    #1;
    chk("rw_t1_cs",    {31'd0, mem_cs1}, 32'd1);
    chk("rw_t1_ready", {31'd0, l1.ld_ready}, 32'd0);
    @(negedge clk); #1;
    chk("rw_t2_oe",    {31'd0, mem_oe1}, 32'd1);
    chk("rw_t2_ready", {31'd0, l1.ld_ready}, 32'd0);
    @(negedge clk); #1;
    chk("rw_turn_cs",     {31'd0, mem_cs1}, 32'd0);
    chk("rw_turn_oe",     {31'd0, mem_oe1}, 32'd0);
    chk("rw_turn_we",     {31'd0, mem_we1}, 32'd0);
    chk("rw_turn_bus",    {24'd0, mem_data1}, {24'd0, C_IDLE_BUS});
    chk("rw_turn_rvalid", {31'd0, l1.fe_rvalid}, 32'd1);
    chk("rw_turn_data",   {24'd0, l1.fe_rdata}, 32'h3C);
    chk("rw_turn_ready",  {31'd0, l1.ld_ready}, 32'd0);
    @(negedge clk); #1;
    chk("rw_idle_ready",  {31'd0, l1.ld_ready}, 32'd1);
    @(negedge clk);
    l1.ld_valid = 1'b0;
    #1;
    chk("rw_wr_we",  {31'd0, mem_we1}, 32'd1);
    chk("rw_wr_bus", {24'd0, mem_data1}, 32'h66);
    @(negedge clk); #1;

    // Asynchronous reset in RD_WAIT
    @(negedge clk);
    l1.fe_req = 1'b1; l1.fe_addr = 8'h10;
    #1;
    n = 0;
    while (!l1.fe_gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    l1.fe_req = 1'b0;
    @(negedge clk); #1;
    chk("ar_pre_oe", {31'd0, mem_oe1}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_cs",   {31'd0, mem_cs1}, 32'd0);
    chk("ar_we",   {31'd0, mem_we1}, 32'd0);
    chk("ar_oe",   {31'd0, mem_oe1}, 32'd0);
    chk("ar_busy", {31'd0, busy1}, 32'd0);
    chk("ar_bus",  {24'd0, mem_data1}, {24'd0, C_IDLE_BUS});
    rv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      #1;
      if (l1.fe_rvalid) rv_seen++;
    end
    chk("ar_no_rvalid", rv_seen, 32'd0);

    // RD_LAT = 3 fetch
    @(negedge clk);
    l3.fe_req = 1'b1; l3.fe_addr = 8'h33;
    #1;
    n = 0;
    while (!l3.fe_gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("l3_grant", {31'd0, l3.fe_gnt}, 32'd1);
    @(negedge clk);
    l3.fe_req = 1'b0;
    #1;
    chk("l3_t1_cs", {31'd0, mem_cs3}, 32'd1);
    chk("l3_t1_oe", {31'd0, mem_oe3}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("l3_wait_oe",     {31'd0, mem_oe3}, 32'd1);
      chk("l3_wait_rvalid", {31'd0, l3.fe_rvalid}, 32'd0);
    end
    @(negedge clk); #1;
    chk("l3_rvalid", {31'd0, l3.fe_rvalid}, 32'd1);
    chk("l3_data",   {24'd0, l3.fe_rdata}, 32'h69);
    chk("l3_oe_off", {31'd0, mem_oe3}, 32'd0);
    @(negedge clk); #1;
    chk("l3_busy",   {31'd0, busy3}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
